// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with bus slave, sticky overflow, level, flush and IRQ.
// Optional macro UART_RX_FIFO_THRESH_EN adds a programmable IRQ threshold.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_rx_dat,
    input  logic       i_rx_stb,
    input  logic [7:0] i_dat,
    output logic [7:0] o_dat,
    input  logic [1:0] i_addr,
    input  logic       i_we,
    input  logic       i_cyc,
    output logic       o_int
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] ONE_LVL  = LW'(1);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [LW-1:0]         level;
    logic [LW-1:0]         level_d;
    logic [LW-1:0]         thr;
    logic                  ov;
    logic                  ov_d;
    logic                  ie;
    logic                  cyc_q;

    logic acc;
    logic rd_acc;
    logic wr_acc;
    logic full;
    logic empty;
    logic pop;
    logic push;
    logic drop;
    logic flush;
    logic ctrl_wr;
    logic [3:0] thr_nib;

    logic unused_ok;
    assign unused_ok = ^i_dat;

    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);

    // Decode the single bus action and the push/pop/flush decisions.
    always_comb begin
        acc     = i_cyc & ~cyc_q;
        rd_acc  = acc & ~i_we;
        wr_acc  = acc & i_we;
        ctrl_wr = wr_acc & (i_addr == 2'd3);
        flush   = ctrl_wr & i_dat[0];
        pop     = rd_acc & (i_addr == 2'd0) & ~empty;
        push    = i_rx_stb & (~full | pop) & ~flush;
        drop    = i_rx_stb & full & ~pop & ~flush;
        level_d = level + LW'(push) - LW'(pop);
        ov_d    = ov;
        if (flush) begin
            level_d = '0;
            ov_d    = 1'b0;
        end else if (drop) begin
            ov_d = 1'b1;
        end else if (rd_acc && i_addr == 2'd1) begin
            ov_d = 1'b0;
        end
    end

`ifdef UART_RX_FIFO_THRESH_EN
    logic [LW-1:0] thr_in;
    logic [LW-1:0] thr_d;

    // Clamp a written threshold into 1..depth.
    always_comb begin
        thr_in = i_dat[LW-1:0];
        thr_d  = thr_in;
        if (thr_in == '0) begin
            thr_d = ONE_LVL;
        end else if (thr_in > FULL_LVL) begin
            thr_d = FULL_LVL;
        end
    end

    // Threshold register, loaded by a write to the LEVEL address.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            thr <= ONE_LVL;
        end else if (wr_acc && i_addr == 2'd2) begin
            thr <= thr_d;
        end
    end

    logic [7:0] thr8;
    assign thr8    = 8'(thr);
    assign thr_nib = thr8[3:0];
`else
    assign thr     = ONE_LVL;
    assign thr_nib = 4'b0;
`endif

    // Byte storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_rx_dat;
        end
    end

    // Pointers, level, flags, edge detect and registered interrupt.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ov     <= 1'b0;
            ie     <= 1'b0;
            cyc_q  <= 1'b0;
            o_int  <= 1'b0;
        end else begin
            cyc_q <= i_cyc;
            level <= level_d;
            ov    <= ov_d;
            o_int <= ie & (level_d >= thr);
            if (ctrl_wr) begin
                ie <= i_dat[1];
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // Combinational register read mux.
    always_comb begin
        o_dat = 8'h00;
        unique case (i_addr)
            2'd0: o_dat = empty ? 8'h00 : mem[rd_ptr];
            2'd1: o_dat = {thr_nib, ie, ov, full, ~empty};
            2'd2: o_dat = 8'(level);
            2'd3: o_dat = {7'b0, ie};
        endcase
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo.
// Reference model: byte queue plus flag variables, updated per clock.
module tb_uart_rx_fifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int LW         = DEPTH_LOG2 + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_dat;
    logic       rx_stb;
    logic [7:0] wdat;
    logic [7:0] rdat;
    logic [1:0] addr;
    logic       we;
    logic       cyc;
    logic       irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    bit m_ov;
    bit m_ie;
    int m_thr;
    bit m_cycq;
    bit m_int;

    uart_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_rx_dat  (rx_dat),
        .i_rx_stb  (rx_stb),
        .i_dat     (wdat),
        .o_dat     (rdat),
        .i_addr    (addr),
        .i_we      (we),
        .i_cyc     (cyc),
        .o_int     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_dat(input logic [1:0] a);
        logic [7:0] t;
        logic [7:0] r;
        t = 8'(m_thr);
`ifndef UART_RX_FIFO_THRESH_EN
        t = 8'h00;
`endif
        case (a)
            2'd0: r = (q.size() == 0) ? 8'h00 : q[0];
            2'd1: r = {t[3:0], m_ie, m_ov, q.size() == DEPTH,
                       q.size() != 0};
            2'd2: r = 8'(q.size());
            default: r = {7'b0, m_ie};
        endcase
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ov   = 0;
        m_ie   = 0;
        m_thr  = 1;
        m_cycq = 0;
        m_int  = 0;
    endtask

    // Called at posedge+1; returns at next posedge+1.
    task automatic cycle(input bit stb, input logic [7:0] rb,
                         input bit c, input bit w,
                         input logic [1:0] a, input logic [7:0] d);
        bit acc, rd, wr, fl, full, pp, ie0;
        int thr0, v;
        rx_stb = stb;
        rx_dat = rb;
        cyc    = c;
        we     = w;
        addr   = a;
        wdat   = d;
        #2;
        check("o_dat", rdat, exp_dat(a));
        @(posedge clk);
        #1;
        acc  = c && !m_cycq;
        rd   = acc && !w;
        wr   = acc && w;
        fl   = wr && a == 2'd3 && d[0];
        full = q.size() == DEPTH;
        ie0  = m_ie;
        thr0 = m_thr;
        pp   = rd && a == 2'd0 && q.size() != 0;
        if (fl) begin
            q.delete();
            m_ov = 0;
        end else begin
            if (rd && a == 2'd1) m_ov = 0;
            if (pp) void'(q.pop_front());
            if (stb) begin
                if (!full || pp) q.push_back(rb);
                else m_ov = 1;
            end
        end
        if (wr && a == 2'd3) m_ie = d[1];
`ifdef UART_RX_FIFO_THRESH_EN
        if (wr && a == 2'd2) begin
            v = int'(d) % (1 << LW);
            if (v == 0) v = 1;
            if (v > DEPTH) v = DEPTH;
            m_thr = v;
        end
`else
        v = 0;
`endif
        m_int  = ie0 && (q.size() >= thr0);
        m_cycq = c;
        check("o_int", {7'b0, irq}, {7'b0, m_int});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 0, 2'd0, 8'h00);
    endtask

    task automatic push(input logic [7:0] b);
        cycle(1, b, 0, 0, 2'd0, 8'h00);
    endtask

    // Single bus access holding cyc for n cycles, then one idle cycle.
    task automatic bus(input bit w, input logic [1:0] a,
                       input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) cycle(0, 8'h00, 1, w, a, d);
        cycle(0, 8'h00, 0, 0, a, 8'h00);
    endtask

    task automatic do_reset();
        rx_stb = 0; rx_dat = 0; cyc = 0; we = 0; addr = 0; wdat = 0;
        rst_n = 0;
        model_reset();
        #2;
        check("rst_int", {7'b0, irq}, 8'h00);
        check("rst_dat", rdat, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        rst_n = 1;
        #1;
        do_reset();
        addr = 2'd1;
        #1;
        check("rst_status", rdat, exp_dat(2'd1));
        addr = 2'd2;
        #1;
        check("rst_level", rdat, 8'h00);
        @(posedge clk);
        #1;

        // Two bytes, ie=1, two held reads
        bus(1, 2'd3, 8'h02, 1);
        push(8'h41);
        push(8'h42);
        idle(1);
        bus(0, 2'd0, 8'h00, 3);
        bus(0, 2'd2, 8'h00, 1);
        bus(0, 2'd0, 8'h00, 3);
        bus(0, 2'd2, 8'h00, 1);

        // Overflow: 17 pushes, status twice, drain
        do_reset();
        for (int i = 1; i <= 17; i++) push(8'(i));
        bus(0, 2'd2, 8'h00, 1);
        bus(0, 2'd1, 8'h00, 2);
        bus(0, 2'd1, 8'h00, 1);
        for (int i = 0; i < 16; i++) bus(0, 2'd0, 8'h00, 1);
        bus(0, 2'd1, 8'h00, 1);

        // Full with pop and push in same cycle
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(8'(8'h80 + i));
        cycle(1, 8'hEE, 1, 0, 2'd0, 8'h00);
        cycle(0, 8'h00, 0, 0, 2'd1, 8'h00);
        for (int i = 0; i < DEPTH; i++) bus(0, 2'd0, 8'h00, 1);

        // Flush with a concurrent push
        do_reset();
        for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
        cycle(1, 8'h99, 1, 1, 2'd3, 8'h01);
        cycle(0, 8'h00, 0, 0, 2'd2, 8'h00);
        bus(0, 2'd0, 8'h00, 1);
        bus(0, 2'd1, 8'h00, 1);

        // Async reset mid-cycle with 3 queued and irq high
        do_reset();
        bus(1, 2'd3, 8'h02, 1);
        for (int i = 0; i < 3; i++) push(8'(8'h30 + i));
        addr = 2'd2;
        #1;
        check("pre_rst_int", {7'b0, irq}, 8'h01);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check("arst_int", {7'b0, irq}, 8'h00);
        check("arst_level", rdat, 8'h00);
        addr = 2'd1;
        #1;
        check("arst_status", rdat, exp_dat(2'd1));
        @(posedge clk);
        #1;
        rst_n = 1;
        idle(1);

`ifdef UART_RX_FIFO_THRESH_EN
        bus(1, 2'd3, 8'h02, 1);
        bus(1, 2'd2, 8'h04, 1);
        for (int i = 0; i < 4; i++) push(8'(8'h50 + i));
        idle(1);
        bus(1, 2'd2, 8'h00, 1);
        bus(0, 2'd1, 8'h00, 1);
        bus(1, 2'd2, 8'hFF, 1);
        bus(0, 2'd1, 8'h00, 1);
`endif

        // Randomized traffic
        begin
            bit c, w, pc;
            logic [1:0] a;
            logic [7:0] d;
            pc = 0; w = 0; a = 0; d = 0;
            for (int n = 0; n < 4000; n++) begin
                c = ($urandom_range(0, 99) < 55);
                if (!(pc && c)) begin
                    w = ($urandom_range(0, 9) < 2);
                    a = 2'($urandom_range(0, 3));
                    d = 8'($urandom);
                    if (w && a == 2'd3 && $urandom_range(0, 7) != 0)
                        d[0] = 1'b0;
                    if (!w && $urandom_range(0, 2) == 0) a = 2'd0;
                end
                cycle($urandom_range(0, 99) < 45, 8'($urandom), c, w, a, d);
                pc = c;
                if (n == 2000) do_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
